// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default constants for the PLL reset/lock sequencer.
// Imported by the sequencer top module.
package pll_rst_seq_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_READY
    } state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_STABLE_CYCLES       = 1024;
    localparam int DEF_CNT_W               = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 2) ? m : 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer.
// Async active-high reset clears both stages to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the async input through two flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification controller on the reference clock.
// Drives pll_rst, qualifies lock, and releases the SerDes reset.
module pll_reset_sequencer
    import pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             pll_rst,
    output logic             serdes_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int MAX_CYC = max3(PLL_RST_CYCLES,
                                  LOCK_TIMEOUT_CYCLES,
                                  STABLE_CYCLES);
    localparam int CW = $clog2(MAX_CYC);

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          locked_s;
    logic          to_inc;
    logic          ll_inc;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // next-state, shared counter and diagnostic increment decode
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        to_inc  = 1'b0;
        ll_inc  = 1'b0;
        if (soft_rst_req) begin
            state_n = S_PLL_RST;
        end else begin
            unique case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST)
                        state_n = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = S_STABLE;
                    end else if (cnt == TO_LAST) begin
                        state_n = S_PLL_RST;
                        to_inc  = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s)
                        state_n = S_WAIT_LOCK;
                    else if (cnt == STAB_LAST)
                        state_n = S_READY;
                end
                S_READY: begin
                    cnt_n = cnt;
                    if (!locked_s) begin
                        state_n = S_PLL_RST;
                        ll_inc  = 1'b1;
                    end
                end
                default: state_n = S_PLL_RST;
            endcase
        end
        // every entry (including a re-entry on request) restarts the count
        if (soft_rst_req || state_n != state)
            cnt_n = '0;
    end

    // state, counter and outputs decoded from the next state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= S_PLL_RST;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            serdes_rst <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pll_rst    <= (state_n == S_PLL_RST);
            serdes_rst <= (state_n != S_READY);
            ready      <= (state_n == S_READY);
        end
    end

    // saturating diagnostic counters, cleared only by rst
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            if (ll_inc && !(&lock_loss_cnt))
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            if (to_inc && !(&timeout_cnt))
                timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

endmodule
